ctu_synch_dl_jl_buf: RTL and testbench
======================================

# ctu_synch_dl_jl_buf

Return-path transfer buffer carrying data from the dram_clk domain to the jbus_clk domain. Everything runs on cmp_clk and uses coincident-edge sync pulses instead of a clock crossing:
- **Capture side:** words are captured when `dram_rx_sync` fires, i.e. on the cmp cycle aligned with a dram_clk edge.
- **Buffering:** captured words are held in a small FIFO.
- **Release side:** one word is released per `jbus_tx_sync` pulse, on the cmp cycle preceding a jbus_clk edge.

This block complements the jbus→dram and cmp→dram synchronizers in the CTU common library, covering the dram→jbus direction with rate-mismatch buffering.

## Interface
Parameters:
- `SIZE`, default 1: data width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥2.
- `PTRW`, default 2: log2(DEPTH).

Ports (one clock; reset is synchronous and active-high):
- `cmp_clk` in 1: sole clock.
- `cmp_rst` in 1: synchronous, active-high reset.
- `dram_rx_sync` in 1: capture strobe, one cmp cycle wide, aligned to the dram_clk edge.
- `jbus_tx_sync` in 1: release strobe, one cmp cycle wide, one cycle before the jbus_clk edge.
- `dl_vld` in 1: `presyncdata` is valid; sampled only when `dram_rx_sync`=1.
- `presyncdata` in SIZE: dram-domain data.
- `ovfl_clr` in 1: clears `ovfl`.
- `syncdata` out SIZE: jbus-domain data, held stable between `jbus_tx_sync` pulses.
- `syncvld` out 1: `syncdata` carries a new word for the current jbus cycle.
- `count` out PTRW+1: occupancy, 0..DEPTH.
- `full` out 1: `count`==DEPTH.
- `empty` out 1: `count`==0.
- `ovfl` out 1: sticky; set when a word was dropped.

## Operation
- **push** = `dram_rx_sync` & `dl_vld` & (!`full` | `pop`).
- **pop** = `jbus_tx_sync` & !`empty`.
- **Push:** writes `presyncdata` at `wr_ptr`, then `wr_ptr`+1, wrapping modulo DEPTH.
- **Pop:** loads the entry at `rd_ptr` into `syncdata`, sets `syncvld`=1, then `rd_ptr`+1, wrapping modulo DEPTH.
- **Empty release:** `jbus_tx_sync` & `empty` gives `syncvld`=0 and `syncdata` holds its old value.
- **No strobe:** with `jbus_tx_sync`=0, `syncdata`/`syncvld` hold. Each word is presented for exactly one jbus period.
- **count update:** `count` += push − pop. Simultaneous push and pop leaves `count` unchanged.
  - Full plus simultaneous pop: the push is accepted (pop frees the slot in the same cycle).
- **Drop:** `dram_rx_sync` & `dl_vld` & `full` & !`pop` drops the word. `ovfl`←1 and the FIFO is unchanged.
- **ovfl_clr:** clears `ovfl`. If a drop occurs in the same cycle, set wins.
- **No-capture cases:** `dl_vld`=0 at `dram_rx_sync` writes nothing. Any `dl_vld` without `dram_rx_sync` is ignored.
- **Occupancy flags:** `full`/`empty` derive from the registered `count`, so they have no combinational path from inputs.
- **Reset** (any cycle, including mid-transfer) gives next cycle:
  - `wr_ptr`=`rd_ptr`=0, `count`=0;
  - `empty`=1, `full`=0;
  - `syncvld`=0, `syncdata`=0, `ovfl`=0;
  - storage contents don't-care.
- **Reset priority:** reset overrides push, pop and strobes in the same cycle.

## Timing
- All outputs are registered and change only on the `cmp_clk` rising edge.
- **Push latency:** a push in cycle t gives `count`/`empty` updated at t+1. The earliest pop of that word is a `jbus_tx_sync` in cycle t+1 (no same-cycle bypass).
- **Pop latency:** a pop in cycle t gives `syncdata`/`syncvld` valid from t+1 until the cycle after the next `jbus_tx_sync`. The one-cycle-early strobe makes the output valid at the jbus_clk edge.
- **Throughput:** one push per `dram_rx_sync` and one pop per `jbus_tx_sync`. Sustained dram rate above jbus rate fills the FIFO and then drops with `ovfl`.
- Strobes may coincide in the same cycle; both take effect.

## Test plan
1. **Reset:** assert `cmp_rst` 2 cycles with `dl_vld`=1 and strobes toggling → `count`=0, `empty`=1, `syncvld`=0, `syncdata`=0, `ovfl`=0.
2. **Single word:** SIZE=8; push 0xA5 at cycle 10, `jbus_tx_sync` at cycle 11 → `syncdata`=0xA5, `syncvld`=1 from cycle 12. Next `jbus_tx_sync` at 20 with FIFO empty → `syncvld`=0 at 21, `syncdata` stays 0xA5.
3. **Fill and overflow:** push 0x01..0x04 with no pops → `full`=1, `count`=4. Push 0x05 → dropped, `ovfl`=1. Then four pops → outputs 0x01,0x02,0x03,0x04 in order, then `empty`=1.
4. **Simultaneous at full:** `count`=4, `dram_rx_sync` and `jbus_tx_sync` in the same cycle with data 0x55 → head popped, 0x55 accepted, `count` stays 4, `ovfl` stays 0.
5. **Wrap-around:** 10 interleaved push/pop pairs (0x10..0x19) → output order preserved across pointer wrap, `count` never exceeds 1.
6. **Overflow vs clear:** `ovfl_clr` in the same cycle as a drop → `ovfl`=1. `ovfl_clr` alone next cycle → `ovfl`=0. Reset with `count`=3 mid-stream → `count`=0 and `syncvld`=0 the following cycle.

Source files
------------

// File: rtl/ctu_synch_dl_jl_buf.sv
// dram->jbus return-path buffer on cmp_clk: captures on dram_rx_sync, releases one word per jbus_tx_sync.
// Latency: a word pushed in cycle t can be popped at t+1 at the earliest; popped data appears on syncdata at the next cycle.
// Backpressure: none upstream; a capture into a full FIFO without a same-cycle pop is dropped and sets sticky ovfl.
module ctu_synch_dl_jl_buf #(
  parameter int SIZE  = 1,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            cmp_clk,
  input  logic            cmp_rst,
  input  logic            dram_rx_sync,
  input  logic            jbus_tx_sync,
  input  logic            dl_vld,
  input  logic [SIZE-1:0] presyncdata,
  input  logic            ovfl_clr,
  output logic [SIZE-1:0] syncdata,
  output logic            syncvld,
  output logic [PTRW:0]   count,
  output logic            full,
  output logic            empty,
  output logic            ovfl
);

  localparam logic [PTRW:0] DEPTH_C = (PTRW+1)'(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [SIZE-1:0] syncdata_q, syncdata_d;
  logic            syncvld_q, syncvld_d;
  logic            ovfl_q, ovfl_d;
  logic            push, pop, drop;

  // Transfer qualification: a pop at full frees the slot the same-cycle push lands in.
  always_comb begin
    pop  = jbus_tx_sync & ~empty_q;
    push = dram_rx_sync & dl_vld & (~full_q | pop);
    drop = dram_rx_sync & dl_vld & full_q & ~pop;
  end

  // Next-state for pointers, occupancy, output word and overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    syncdata_d = syncdata_q;
    syncvld_d  = syncvld_q;
    ovfl_d     = ovfl_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Each strobe starts a new jbus period: present the head word, or flag no data.
    if (jbus_tx_sync) begin
      syncvld_d = pop;
      if (pop) syncdata_d = mem_q[rd_ptr_q];
    end

    // A drop wins over a simultaneous clear so the loss is never hidden.
    if (drop)          ovfl_d = 1'b1;
    else if (ovfl_clr) ovfl_d = 1'b0;

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // Control and output registers; reset overrides every strobe.
  always_ff @(posedge cmp_clk) begin
    if (cmp_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      syncdata_q <= '0;
      syncvld_q  <= 1'b0;
      ovfl_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      syncdata_q <= syncdata_d;
      syncvld_q  <= syncvld_d;
      ovfl_q     <= ovfl_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge cmp_clk) begin
    if (push && !cmp_rst) mem_q[wr_ptr_q] <= presyncdata;
  end

  assign syncdata = syncdata_q;
  assign syncvld  = syncvld_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign ovfl     = ovfl_q;

endmodule

// File: tb/tb_ctu_synch_dl_jl_buf.sv
// Bench for ctu_synch_dl_jl_buf: queue scoreboard drives strobes cycle by cycle and checks every output.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: modelled by the bench's own full/empty tracking of the scoreboard queue.
module tb_ctu_synch_dl_jl_buf;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  logic            cmp_clk = 1'b0;
  logic            cmp_rst;
  logic            dram_rx_sync;
  logic            jbus_tx_sync;
  logic            dl_vld;
  logic [SIZE-1:0] presyncdata;
  logic            ovfl_clr;
  logic [SIZE-1:0] syncdata;
  logic            syncvld;
  logic [PTRW:0]   count;
  logic            full;
  logic            empty;
  logic            ovfl;

  ctu_synch_dl_jl_buf #(.SIZE(SIZE), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .cmp_clk      (cmp_clk),
    .cmp_rst      (cmp_rst),
    .dram_rx_sync (dram_rx_sync),
    .jbus_tx_sync (jbus_tx_sync),
    .dl_vld       (dl_vld),
    .presyncdata  (presyncdata),
    .ovfl_clr     (ovfl_clr),
    .syncdata     (syncdata),
    .syncvld      (syncvld),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .ovfl         (ovfl)
  );

  always #5 cmp_clk = ~cmp_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard state
  logic [SIZE-1:0] sb_q[$];
  logic [SIZE-1:0] exp_data;
  logic            exp_vld;
  logic            exp_ovfl;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".syncvld"},  32'(syncvld),  32'(exp_vld));
    chk({tag, ".syncdata"}, 32'(syncdata), 32'(exp_data));
    chk({tag, ".count"},    32'(count),    32'(sb_q.size()));
    chk({tag, ".full"},     32'(full),     32'(sb_q.size() == DEPTH));
    chk({tag, ".empty"},    32'(empty),    32'(sb_q.size() == 0));
    chk({tag, ".ovfl"},     32'(ovfl),     32'(exp_ovfl));
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic cyc(input string tag, input logic rx, input logic tx, input logic vld,
                     input logic [SIZE-1:0] d, input logic clr);
    logic m_full, m_empty, m_pop, m_push, m_drop;
    dram_rx_sync = rx;
    jbus_tx_sync = tx;
    dl_vld       = vld;
    presyncdata  = d;
    ovfl_clr     = clr;
    m_full  = (sb_q.size() == DEPTH);
    m_empty = (sb_q.size() == 0);
    m_pop   = tx & ~m_empty;
    m_push  = rx & vld & (~m_full | m_pop);
    m_drop  = rx & vld & m_full & ~m_pop;
    if (tx) begin
      exp_vld = m_pop;
      if (m_pop) exp_data = sb_q.pop_front();
    end
    if (m_push) sb_q.push_back(d);
    if (m_drop)   exp_ovfl = 1'b1;
    else if (clr) exp_ovfl = 1'b0;
    @(posedge cmp_clk);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    cmp_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dram_rx_sync = 1'(i);
      jbus_tx_sync = 1'(1 - i);
      dl_vld       = 1'b1;
      presyncdata  = 8'hEE;
      ovfl_clr     = 1'b0;
      @(posedge cmp_clk);
      #1;
    end
    cmp_rst = 1'b0;
    dram_rx_sync = 1'b0;
    jbus_tx_sync = 1'b0;
    dl_vld       = 1'b0;
    sb_q.delete();
    exp_vld  = 1'b0;
    exp_data = '0;
    exp_ovfl = 1'b0;
    chk_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    cmp_rst = 1'b1;
    dram_rx_sync = 1'b0;
    jbus_tx_sync = 1'b0;
    dl_vld = 1'b0;
    presyncdata = '0;
    ovfl_clr = 1'b0;

    // 1. Reset with strobes active
    do_reset("reset");

    // 2. Single word, then empty release holds data
    idle(3);
    cyc("push_a5", 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    cyc("pop_a5",  1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(8);
    cyc("rel_empty", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // Ignored captures: vld without strobe, strobe without vld; no same-cycle bypass
    cyc("vld_no_rx", 1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    cyc("rx_no_vld", 1'b1, 1'b0, 1'b0, 8'h66, 1'b0);
    cyc("no_bypass", 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
    cyc("pop_3c",    1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 3. Fill, overflow, drain
    for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
    cyc("drop_05", 1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(1);
    end
    cyc("clr", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // 4. Simultaneous push/pop at full
    for (int i = 0; i < 4; i++) cyc("fill2", 1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    cyc("full_both", 1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) cyc("drain2", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 5. Wrap-around with interleaved push/pop pairs
    for (int i = 0; i < 10; i++) begin
      cyc("wrap_push", 1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      cyc("wrap_pop",  1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    end

    // 6. Drop and clear in the same cycle, clear alone, reset mid-stream
    for (int i = 0; i < 4; i++) cyc("fill3", 1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    cyc("drop_clr", 1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
    cyc("clr_only", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc("pop_pre_rst", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    do_reset("reset_mid");

    // Random strobe mix
    for (int i = 0; i < 200; i++)
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
